// File: rtl/imuldiv_muldiv_dispatch.sv
// rtl/imuldiv_muldiv_dispatch.sv - muldiv front end: decode fn, issue to mul/div unit, return 64-bit result
module imuldiv_muldiv_dispatch #(
    parameter int FN_W  = 3,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,

    input  logic [FN_W-1:0]  muldivreq_msg_fn,
    input  logic [31:0]      muldivreq_msg_a,
    input  logic [31:0]      muldivreq_msg_b,
    input  logic             muldivreq_val,
    output logic             muldivreq_rdy,

    output logic [63:0]      muldivresp_msg_result,
    output logic             muldivresp_val,
    input  logic             muldivresp_rdy,

    output logic [31:0]      mulreq_msg_a,
    output logic [31:0]      mulreq_msg_b,
    output logic             mulreq_val,
    input  logic             mulreq_rdy,
    input  logic [63:0]      mulresp_msg_result,
    input  logic             mulresp_val,
    output logic             mulresp_rdy,

    output logic [1:0]       divreq_msg_fn,
    output logic [31:0]      divreq_msg_a,
    output logic [31:0]      divreq_msg_b,
    output logic             divreq_val,
    input  logic             divreq_rdy,
    input  logic [63:0]      divresp_msg_result,
    input  logic             divresp_val,
    output logic             divresp_rdy,

    output logic [CNT_W-1:0] ops_done
);

    localparam logic [FN_W-1:0] FN_MUL      = FN_W'(0);
    localparam logic [FN_W-1:0] FN_MAX_LEGAL = FN_W'(4);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t           state_q,    state_d;
    logic [FN_W-1:0]  fn_q,       fn_d;
    logic [31:0]      a_q,        a_d;
    logic [31:0]      b_q,        b_d;
    logic [63:0]      result_q,   result_d;
    logic [CNT_W-1:0] ops_done_q, ops_done_d;

    logic sel_mul;
    logic in_idle;
    logic req_fire;
    logic unit_req_fire;
    logic unit_resp_fire;
    logic out_fire;

    // Unit select comes from the latched fn so it is stable for the whole operation.
    assign sel_mul = (fn_q == FN_MUL);
    assign in_idle = (state_q == S_IDLE);

    // Every handshake output is a decode of registered state only; request
    // ready is additionally held low while reset is asserted.
    assign muldivreq_rdy  = in_idle && !reset;
    assign mulreq_val     = (state_q == S_ISSUE) &&  sel_mul;
    assign divreq_val     = (state_q == S_ISSUE) && !sel_mul;
    assign mulresp_rdy    = (state_q == S_WAIT)  &&  sel_mul;
    assign divresp_rdy    = (state_q == S_WAIT)  && !sel_mul;
    assign muldivresp_val = (state_q == S_RESP);

    assign muldivresp_msg_result = result_q;
    assign mulreq_msg_a  = a_q;
    assign mulreq_msg_b  = b_q;
    assign divreq_msg_a  = a_q;
    assign divreq_msg_b  = b_q;
    // Divider encoding is the pipeline encoding shifted down by one (DIV=1 -> 0).
    assign divreq_msg_fn = 2'(fn_q - FN_W'(1));
    assign ops_done      = ops_done_q;

    assign req_fire       = muldivreq_val && muldivreq_rdy;
    assign unit_req_fire  = sel_mul ? (mulreq_val && mulreq_rdy) : (divreq_val && divreq_rdy);
    assign unit_resp_fire = sel_mul ? (mulresp_val && mulresp_rdy) : (divresp_val && divresp_rdy);
    assign out_fire       = muldivresp_val && muldivresp_rdy;

    // Next-state and datapath register updates for the four-state dispatch FSM.
    always_comb begin
        state_d    = state_q;
        fn_d       = fn_q;
        a_d        = a_q;
        b_d        = b_q;
        result_d   = result_q;
        ops_done_d = ops_done_q;
        case (state_q)
            S_IDLE: begin
                if (req_fire) begin
                    fn_d = muldivreq_msg_fn;
                    a_d  = muldivreq_msg_a;
                    b_d  = muldivreq_msg_b;
                    if (muldivreq_msg_fn <= FN_MAX_LEGAL) begin
                        state_d = S_ISSUE;
                    end else begin
                        // Illegal function: answer zero without touching either unit.
                        result_d = 64'd0;
                        state_d  = S_RESP;
                    end
                end
            end
            S_ISSUE: begin
                if (unit_req_fire) begin
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                // Only the selected unit's response can fire; the other unit's
                // resp_rdy is low so a stray valid from it is never consumed.
                if (unit_resp_fire) begin
                    result_d = sel_mul ? mulresp_msg_result : divresp_msg_result;
                    state_d  = S_RESP;
                end
            end
            S_RESP: begin
                if (out_fire) begin
                    ops_done_d = ops_done_q + CNT_W'(1);
                    state_d    = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset abandons any in-flight operation.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= S_IDLE;
            fn_q       <= '0;
            a_q        <= '0;
            b_q        <= '0;
            result_q   <= '0;
            ops_done_q <= '0;
        end else begin
            state_q    <= state_d;
            fn_q       <= fn_d;
            a_q        <= a_d;
            b_q        <= b_d;
            result_q   <= result_d;
            ops_done_q <= ops_done_d;
        end
    end

endmodule

// File: tb/tb_imuldiv_muldiv_dispatch.sv
// tb/tb_imuldiv_muldiv_dispatch.sv - randomized bench with transaction model and mul/div unit stubs
module tb_imuldiv_muldiv_dispatch;

    localparam int FN_W  = 3;
    localparam int CNT_W = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic [FN_W-1:0]  muldivreq_msg_fn;
    logic [31:0]      muldivreq_msg_a, muldivreq_msg_b;
    logic             muldivreq_val, muldivreq_rdy;
    logic [63:0]      muldivresp_msg_result;
    logic             muldivresp_val, muldivresp_rdy;
    logic [31:0]      mulreq_msg_a, mulreq_msg_b;
    logic             mulreq_val, mulreq_rdy;
    logic [63:0]      mulresp_msg_result;
    logic             mulresp_val, mulresp_rdy;
    logic [1:0]       divreq_msg_fn;
    logic [31:0]      divreq_msg_a, divreq_msg_b;
    logic             divreq_val, divreq_rdy;
    logic [63:0]      divresp_msg_result;
    logic             divresp_val, divresp_rdy;
    logic [CNT_W-1:0] ops_done;

    imuldiv_muldiv_dispatch #(.FN_W(FN_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .muldivreq_msg_fn(muldivreq_msg_fn), .muldivreq_msg_a(muldivreq_msg_a),
        .muldivreq_msg_b(muldivreq_msg_b), .muldivreq_val(muldivreq_val),
        .muldivreq_rdy(muldivreq_rdy),
        .muldivresp_msg_result(muldivresp_msg_result), .muldivresp_val(muldivresp_val),
        .muldivresp_rdy(muldivresp_rdy),
        .mulreq_msg_a(mulreq_msg_a), .mulreq_msg_b(mulreq_msg_b), .mulreq_val(mulreq_val),
        .mulreq_rdy(mulreq_rdy), .mulresp_msg_result(mulresp_msg_result),
        .mulresp_val(mulresp_val), .mulresp_rdy(mulresp_rdy),
        .divreq_msg_fn(divreq_msg_fn), .divreq_msg_a(divreq_msg_a), .divreq_msg_b(divreq_msg_b),
        .divreq_val(divreq_val), .divreq_rdy(divreq_rdy),
        .divresp_msg_result(divresp_msg_result), .divresp_val(divresp_val),
        .divresp_rdy(divresp_rdy),
        .ops_done(ops_done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Architectural result of each operation: signed 64-bit product, or {remainder, quotient}.
    function automatic logic [63:0] gold(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b);
        logic signed [63:0] sa, sb;
        logic signed [31:0] q, r;
        case (fn)
            3'd0: begin
                sa = {{32{a[31]}}, a};
                sb = {{32{b[31]}}, b};
                return sa * sb;
            end
            3'd1, 3'd3: begin
                q = $signed(a) / $signed(b);
                r = $signed(a) % $signed(b);
                return {r, q};
            end
            3'd2, 3'd4: return {a % b, a / b};
            default:    return 64'd0;
        endcase
    endfunction

    // Stub controls written by the main sequence.
    int mul_lat = 0, mul_stall = 0, mul_stale = 0;
    int div_lat = 0, div_stall = 0;

    // Multiplier stub: accepts when idle and not stalled, replies after mul_lat cycles.
    bit          m_pend, m_acc, m_done;
    int          m_cnt;
    logic [63:0] m_res;
    initial begin
        mulreq_rdy = 1'b1; mulresp_val = 1'b0; mulresp_msg_result = '0;
        m_pend = 0; m_cnt = 0; m_res = '0;
        forever begin
            @(negedge clk);
            m_acc = 0; m_done = 0;
            if (reset) begin
                m_pend = 0;
            end else begin
                m_acc  = mulreq_val && mulreq_rdy;
                m_done = mulresp_val && mulresp_rdy;
                if (mulreq_val && !mulreq_rdy && mul_stall > 0) mul_stall--;
                if (m_acc) begin
                    m_pend = 1; m_cnt = mul_lat; m_res = gold(3'd0, mulreq_msg_a, mulreq_msg_b);
                end
            end
            @(posedge clk); #1;
            if (m_done) m_pend = 0;
            mulresp_val = 1'b0;
            if (mul_stale > 0) begin
                mulresp_val = 1'b1; mulresp_msg_result = 64'hDEAD_BEEF_0BAD_F00D; mul_stale--;
            end else if (m_pend) begin
                if (m_cnt == 0) begin
                    mulresp_val = 1'b1; mulresp_msg_result = m_res;
                end else begin
                    m_cnt--;
                end
            end
            mulreq_rdy = !m_pend && (mul_stall == 0);
        end
    end

    // Divider stub: same protocol, result computed from the divider fn code.
    bit          d_pend, d_acc, d_done;
    int          d_cnt;
    logic [63:0] d_res;
    initial begin
        divreq_rdy = 1'b1; divresp_val = 1'b0; divresp_msg_result = '0;
        d_pend = 0; d_cnt = 0; d_res = '0;
        forever begin
            @(negedge clk);
            d_acc = 0; d_done = 0;
            if (reset) begin
                d_pend = 0;
            end else begin
                d_acc  = divreq_val && divreq_rdy;
                d_done = divresp_val && divresp_rdy;
                if (divreq_val && !divreq_rdy && div_stall > 0) div_stall--;
                if (d_acc) begin
                    d_pend = 1; d_cnt = div_lat;
                    d_res  = gold(3'({1'b0, divreq_msg_fn} + 3'd1), divreq_msg_a, divreq_msg_b);
                end
            end
            @(posedge clk); #1;
            if (d_done) d_pend = 0;
            divresp_val = 1'b0;
            if (d_pend) begin
                if (d_cnt == 0) begin
                    divresp_val = 1'b1; divresp_msg_result = d_res;
                end else begin
                    d_cnt--;
                end
            end
            divreq_rdy = !d_pend && (div_stall == 0);
        end
    end

    // Transaction model: one operation at a time, tracked by the handshakes that complete.
    bit          have_op, issued, got;
    logic [2:0]  op_fn;
    logic [31:0] op_a, op_b;
    logic [63:0] exp_res;
    int          done_cnt;
    int          unit_val_cycles;
    initial begin
        have_op = 0; issued = 0; got = 0; op_fn = '0; op_a = '0; op_b = '0;
        exp_res = '0; done_cnt = 0; unit_val_cycles = 0;
    end

    // Per-cycle compare of every DUT output against the model, then model advance.
    always @(negedge clk) begin
        bit e_rdy, e_mv, e_dv, e_mr, e_dr, e_ov, legal, ismul;
        if (reset) begin
            chk("rst_req_rdy",  64'(muldivreq_rdy),  64'd0);
            chk("rst_resp_val", 64'(muldivresp_val), 64'd0);
            chk("rst_mul_val",  64'(mulreq_val),     64'd0);
            chk("rst_div_val",  64'(divreq_val),     64'd0);
            chk("rst_mul_rdy",  64'(mulresp_rdy),    64'd0);
            chk("rst_div_rdy",  64'(divresp_rdy),    64'd0);
            chk("rst_ops_done", 64'(ops_done),       64'd0);
            have_op = 0; issued = 0; got = 0; done_cnt = 0;
        end else begin
            legal = (op_fn <= 3'd4);
            ismul = (op_fn == 3'd0);
            e_rdy = !have_op;
            e_mv  = have_op && ismul && !issued;
            e_dv  = have_op && legal && !ismul && !issued;
            e_mr  = have_op && ismul && issued && !got;
            e_dr  = have_op && legal && !ismul && issued && !got;
            e_ov  = have_op && got;
            chk("req_rdy",  64'(muldivreq_rdy),  64'(e_rdy));
            chk("mul_val",  64'(mulreq_val),     64'(e_mv));
            chk("div_val",  64'(divreq_val),     64'(e_dv));
            chk("mul_rrdy", 64'(mulresp_rdy),    64'(e_mr));
            chk("div_rrdy", 64'(divresp_rdy),    64'(e_dr));
            chk("resp_val", 64'(muldivresp_val), 64'(e_ov));
            chk("ops_done", 64'(ops_done),       64'(done_cnt));
            if (e_mv) begin
                chk("mul_a", 64'(mulreq_msg_a), 64'(op_a));
                chk("mul_b", 64'(mulreq_msg_b), 64'(op_b));
            end
            if (e_dv) begin
                chk("div_fn", 64'(divreq_msg_fn), 64'(op_fn - 3'd1));
                chk("div_a",  64'(divreq_msg_a),  64'(op_a));
                chk("div_b",  64'(divreq_msg_b),  64'(op_b));
            end
            if (e_ov) chk("result", muldivresp_msg_result, exp_res);
            if (mulreq_val || divreq_val) unit_val_cycles++;

            if (e_ov && muldivresp_rdy) begin
                have_op = 0; done_cnt = (done_cnt + 1) % (1 << CNT_W);
            end
            if ((e_mr && mulresp_val) || (e_dr && divresp_val)) begin
                got = 1; exp_res = gold(op_fn, op_a, op_b);
            end
            if ((e_mv && mulreq_rdy) || (e_dv && divreq_rdy)) issued = 1;
            if (e_rdy && muldivreq_val) begin
                have_op = 1; op_fn = muldivreq_msg_fn; op_a = muldivreq_msg_a; op_b = muldivreq_msg_b;
                issued = 0; got = 0;
                if (muldivreq_msg_fn > 3'd4) begin
                    issued = 1; got = 1; exp_res = 64'd0;
                end
            end
        end
    end

    task automatic note_timeout(input string name, input bit ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s timeout actual=expired required=handshake", name);
        end
    endtask

    // One full operation from the pipeline side; hold = cycles to stall the response.
    task automatic send(input logic [2:0] fn, input logic [31:0] a, input logic [31:0] b,
                        input int hold, output logic [63:0] res, output int lat);
        int n, seen;
        bit done;
        muldivreq_msg_fn = fn; muldivreq_msg_a = a; muldivreq_msg_b = b; muldivreq_val = 1'b1;
        muldivresp_rdy = (hold == 0);
        n = 0; done = 0;
        while (!done && n < 100) begin
            @(negedge clk); done = muldivreq_rdy; n++;
            @(posedge clk); #1;
        end
        muldivreq_val = 1'b0;
        muldivreq_msg_a = $urandom; muldivreq_msg_b = $urandom;
        note_timeout("req_accept", done);
        lat = 0; seen = 0; n = 0; done = 0; res = '0;
        while (!done && n < 200) begin
            @(negedge clk); n++;
            if (muldivresp_val) begin
                if (lat == 0) lat = n;
                if (muldivresp_rdy) begin
                    done = 1; res = muldivresp_msg_result;
                end else begin
                    seen++;
                end
            end
            @(posedge clk); #1;
            if (seen >= hold) muldivresp_rdy = 1'b1;
        end
        muldivresp_rdy = 1'b0;
        note_timeout("resp_return", done);
    endtask

    logic [63:0] res;
    int          lat;
    initial begin
        logic [2:0]  rfn;
        logic [31:0] ra, rb;
        bit          ok;
        reset = 1'b1; muldivreq_val = 1'b0; muldivreq_msg_fn = '0;
        muldivreq_msg_a = '0; muldivreq_msg_b = '0; muldivresp_rdy = 1'b0;

        chk("gold_mul",  gold(3'd0, 32'd3, 32'hFFFF_FFFC), 64'hFFFF_FFFF_FFFF_FFF4);
        chk("gold_divu", gold(3'd2, 32'd7, 32'd2),         64'h0000_0001_0000_0003);
        chk("gold_div",  gold(3'd1, 32'hFFFF_FFF9, 32'd2), 64'hFFFF_FFFF_FFFF_FFFD);
        chk("gold_ill",  gold(3'd6, 32'd5, 32'd5),         64'd0);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        mul_lat = 5; unit_val_cycles = 0;
        send(3'd0, 32'd3, 32'hFFFF_FFFC, 0, res, lat);
        chk("t_mul_result", res, 64'hFFFF_FFFF_FFFF_FFF4);
        chk("t_mul_val_cycles", 64'(unit_val_cycles), 64'd1);
        @(negedge clk); chk("t_mul_ops_done", 64'(ops_done), 64'd1);
        @(posedge clk); #1;

        div_lat = 2; unit_val_cycles = 0;
        send(3'd2, 32'd7, 32'd2, 0, res, lat);
        chk("t_divu_result", res, 64'h0000_0001_0000_0003);
        chk("t_divu_val_cycles", 64'(unit_val_cycles), 64'd1);

        mul_lat = 1; mul_stall = 4; unit_val_cycles = 0;
        send(3'd0, 32'd9, 32'd11, 0, res, lat);
        chk("t_bp_result", res, 64'd99);
        chk("t_bp_val_cycles", 64'(unit_val_cycles), 64'd5);

        div_lat = 0;
        send(3'd4, 32'd100, 32'd7, 3, res, lat);
        chk("t_stall_result", res, 64'h0000_0002_0000_000E);

        unit_val_cycles = 0;
        send(3'd6, 32'd1, 32'd2, 0, res, lat);
        chk("t_ill_result", res, 64'd0);
        chk("t_ill_latency", 64'(lat), 64'd1);
        chk("t_ill_val_cycles", 64'(unit_val_cycles), 64'd0);

        // Reset while waiting on a slow multiply, then a stale response from the unit.
        mul_lat = 20;
        muldivreq_msg_fn = 3'd0; muldivreq_msg_a = 32'd4; muldivreq_msg_b = 32'd4; muldivreq_val = 1'b1;
        ok = 0;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge clk);
            if (!muldivreq_rdy) muldivreq_val = 1'b0;
            ok = mulresp_rdy;
        end
        muldivreq_val = 1'b0;
        note_timeout("t_rst_reach_wait", ok);
        #2 reset = 1'b1;
        #1;
        chk("t_rst_async_req_rdy",  64'(muldivreq_rdy), 64'd0);
        chk("t_rst_async_mul_rrdy", 64'(mulresp_rdy),   64'd0);
        chk("t_rst_async_ops_done", 64'(ops_done),      64'd0);
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        mul_stale = 3;
        repeat (6) @(posedge clk);
        #1;
        mul_lat = 0;
        send(3'd0, 32'd5, 32'd6, 0, res, lat);
        chk("t_rst_next_result", res, 64'd30);
        chk("t_min_latency", 64'(lat), 64'd3);
        @(negedge clk); chk("t_rst_ops_done", 64'(ops_done), 64'd1);
        @(posedge clk); #1;

        // Randomized traffic; ops_done wraps several times with the narrow counter.
        for (int t = 0; t < 200; t++) begin
            rfn = ($urandom_range(0, 9) < 8) ? 3'($urandom_range(0, 4)) : 3'($urandom_range(5, 7));
            ra = $urandom; rb = $urandom;
            if (rb == 32'd0) rb = 32'd1;
            if (ra == 32'h8000_0000) ra = 32'd1;
            mul_lat = $urandom_range(0, 4); div_lat = $urandom_range(0, 4);
            mul_stall = $urandom_range(0, 3); div_stall = $urandom_range(0, 3);
            send(rfn, ra, rb, $urandom_range(0, 3), res, lat);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
